// File: rtl/text_line_renderer.sv
// Purpose: renders one text-layer scanline: fetches COLS map entries, looks up glyph rows, writes COLS*8 palette indices.
// Latency: done one cycle after start for an out-of-range line; otherwise 11 cycles per character plus map_ack wait, done with the last write.
// Backpressure: map_req/map_addr held stable until map_ack; ROM is fixed one-cycle latency; line buffer writes never stall.
module text_line_renderer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  line,
    output logic        busy,
    output logic        done,
    output logic        map_req,
    output logic [11:0] map_addr,
    input  logic        map_ack,
    input  logic [15:0] map_data,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        lb_wr_en,
    output logic [9:0]  lb_wr_addr,
    output logic [7:0]  lb_wr_data
);
    localparam int              CW        = $clog2(COLS);
    localparam logic [9:0]      NUM_LINES = 10'(ROWS * 16);
    localparam logic [CW-1:0]   LAST_COL  = CW'(COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ROM, S_DATA, S_EMIT, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [8:0]    line_q, line_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    pix_q, pix_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    fg_q, fg_d;
    logic [3:0]    bg_q, bg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          map_req_q, map_req_d;
    logic [11:0]   map_addr_q, map_addr_d;
    logic [11:0]   rom_addr_q, rom_addr_d;
    logic          lb_wr_en_q, lb_wr_en_d;
    logic [9:0]    lb_wr_addr_q, lb_wr_addr_d;
    logic [7:0]    lb_wr_data_q, lb_wr_data_d;

    // Map entry index for a text row and column; never exceeds 12 bits for valid rows.
    function automatic logic [11:0] entry_addr(input logic [4:0] row, input logic [CW-1:0] c);
        return 12'(row) * 12'(COLS) + 12'(c);
    endfunction

    // Next-state and registered-output computation; done and lb_wr_en are pulses, everything else holds.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        col_d        = col_q;
        pix_d        = pix_q;
        shift_d      = shift_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        map_req_d    = map_req_q;
        map_addr_d   = map_addr_q;
        rom_addr_d   = rom_addr_q;
        lb_wr_en_d   = 1'b0;
        lb_wr_addr_d = lb_wr_addr_q;
        lb_wr_data_d = lb_wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ({1'b0, line} < NUM_LINES) begin
                        line_d     = line;
                        col_d      = '0;
                        busy_d     = 1'b1;
                        map_req_d  = 1'b1;
                        map_addr_d = entry_addr(line[8:4], '0);
                        state_d    = S_FETCH;
                    end else begin
                        // Off-screen line: report completion without touching the buses.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end
                end
            end
            S_FETCH: begin
                if (map_ack && map_req_q) begin
                    map_req_d  = 1'b0;
                    fg_d       = map_data[11:8];
                    bg_d       = map_data[15:12];
                    rom_addr_d = {map_data[7:0], line_q[3:0]};
                    state_d    = S_ROM;
                end
            end
            S_ROM: begin
                // rom_addr is sampled by the ROM at the end of this cycle.
                state_d = S_DATA;
            end
            S_DATA: begin
                shift_d = rom_data;
                pix_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                lb_wr_en_d   = 1'b1;
                lb_wr_addr_d = 10'({col_q, pix_q});
                lb_wr_data_d = {4'b0, shift_q[7] ? fg_q : bg_q};
                shift_d      = {shift_q[6:0], 1'b0};
                pix_d        = pix_q + 3'd1;
                if (pix_q == 3'd7) begin
                    if (col_q < LAST_COL) begin
                        col_d      = col_q + CW'(1);
                        map_req_d  = 1'b1;
                        map_addr_d = entry_addr(line_q[8:4], col_q + CW'(1));
                        state_d    = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                // done is high for this single cycle; start is ignored here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any line in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            col_q        <= '0;
            pix_q        <= '0;
            shift_q      <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            map_req_q    <= 1'b0;
            map_addr_q   <= '0;
            rom_addr_q   <= '0;
            lb_wr_en_q   <= 1'b0;
            lb_wr_addr_q <= '0;
            lb_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            col_q        <= col_d;
            pix_q        <= pix_d;
            shift_q      <= shift_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            map_req_q    <= map_req_d;
            map_addr_q   <= map_addr_d;
            rom_addr_q   <= rom_addr_d;
            lb_wr_en_q   <= lb_wr_en_d;
            lb_wr_addr_q <= lb_wr_addr_d;
            lb_wr_data_q <= lb_wr_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign map_req    = map_req_q;
    assign map_addr   = map_addr_q;
    assign rom_addr   = rom_addr_q;
    assign lb_wr_en   = lb_wr_en_q;
    assign lb_wr_addr = lb_wr_addr_q;
    assign lb_wr_data = lb_wr_data_q;

endmodule
